// File: rtl/semi_pkg.sv
// semi_pkg: shared types and constants for the semigraphics cell sequencer.
//   - fetch_state_t : prefetch FSM states (IDLE / REQ / FULL)
//   - DEF_CELL_PIX, DEF_CELL_ROWS : default cell geometry
//   - SG4/SG6 segment boundaries (first row of each block row above 0)
package semi_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FULL = 2'd2
  } fetch_state_t;

  localparam int DEF_CELL_PIX  = 8;
  localparam int DEF_CELL_ROWS = 12;

  // SG4: two block rows, split at row 6
  localparam logic [3:0] SG4_SPLIT  = 4'd6;
  // SG6: three block rows, split at rows 4 and 8
  localparam logic [3:0] SG6_SPLIT0 = 4'd4;
  localparam logic [3:0] SG6_SPLIT1 = 4'd8;

endpackage

// File: rtl/semi_row_tracker.sv
// semi_row_tracker: scan line within the character row and block segment decode.
//   clk, rst_n   : clock, async active-low reset
//   field_start  : start of active field, row -> 0 and arms first-line skip
//   line_start   : first pixel of an active line, advances the row
//   sel          : registered SG6(1)/SG4(0) select of the current cell
//   row          : scan line within the cell, 0..CELL_ROWS-1
//   seg          : block row index for the SG4/SG6 generators (0..2)
module semi_row_tracker
  import semi_pkg::*;
#(
  parameter int CELL_ROWS = DEF_CELL_ROWS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       field_start,
  input  logic       line_start,
  input  logic       sel,
  output logic [3:0] row,
  output logic [1:0] seg
);

  localparam logic [3:0] ROW_LAST = 4'(CELL_ROWS - 1);

  logic first_line;

  // The first line of a field is already row 0, so its LineStart must not
  // advance the row; first_line swallows exactly that one pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row        <= '0;
      first_line <= 1'b1;
    end else if (field_start) begin
      row        <= '0;
      first_line <= ~line_start;
    end else if (line_start) begin
      if (first_line) first_line <= 1'b0;
      else            row        <= (row == ROW_LAST) ? 4'd0 : row + 4'd1;
    end
  end

  always_comb begin
    seg = 2'd0;
    if (sel) begin
      if      (row >= SG6_SPLIT1) seg = 2'd2;
      else if (row >= SG6_SPLIT0) seg = 2'd1;
    end else if (row >= SG4_SPLIT) begin
      seg = 2'd1;
    end
  end

endmodule

// File: rtl/semi_cell_sequencer.sv
// semi_cell_sequencer: per-cell display byte fetch for the semigraphics path.
//   Clk, nReset      : clock, async active-low reset
//   PixEn            : one pulse per pixel
//   LineStart        : first pixel of an active line (forces a cell load)
//   FieldStart       : start of active field (row reset, clears Underrun)
//   VData, InE       : fetched byte and INT/EXT select, valid with ByteAck
//   ByteAck          : memory response to ByteReq
//   ByteReq          : level request for the next byte (one-deep prefetch)
//   CellByte, SelE   : byte and select of the cell being displayed
//   PixCol           : pixel column within the cell
//   RowInCell        : scan line within the cell
//   Segment          : block row index for the SG4/SG6 generators
//   Underrun         : sticky, a load found no byte available
module semi_cell_sequencer
  import semi_pkg::*;
#(
  parameter int CELL_PIX  = DEF_CELL_PIX,
  parameter int CELL_ROWS = DEF_CELL_ROWS
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic       PixEn,
  input  logic       LineStart,
  input  logic       FieldStart,
  input  logic [7:0] VData,
  input  logic       InE,
  input  logic       ByteAck,
  output logic       ByteReq,
  output logic [7:0] CellByte,
  output logic       SelE,
  output logic [2:0] PixCol,
  output logic [3:0] RowInCell,
  output logic [1:0] Segment,
  output logic       Underrun
);

  localparam logic [2:0] COL_LAST = 3'(CELL_PIX - 1);

  fetch_state_t state;
  logic         armed;
  logic [7:0]   fbuf_byte;
  logic         fbuf_sel;
  logic         cell_load;

  assign cell_load = LineStart | (PixEn & (PixCol == COL_LAST));

  // Underrun is cleared by FieldStart but a load failing in the same cycle
  // sets it again (later assignment wins), so a real underrun is never lost.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state     <= S_IDLE;
      armed     <= 1'b0;
      ByteReq   <= 1'b0;
      fbuf_byte <= '0;
      fbuf_sel  <= 1'b0;
      CellByte  <= '0;
      SelE      <= 1'b0;
      PixCol    <= '0;
      Underrun  <= 1'b0;
    end else begin
      if (cell_load)  PixCol <= '0;
      else if (PixEn) PixCol <= PixCol + 3'd1;

      if (FieldStart) Underrun <= 1'b0;

      case (state)
        // First edge after reset release only arms; the request goes out on
        // the second edge. A load here has nothing to show.
        S_IDLE: begin
          armed <= 1'b1;
          if (armed) begin
            state   <= S_REQ;
            ByteReq <= 1'b1;
          end
          if (cell_load) begin
            CellByte <= '0;
            SelE     <= 1'b0;
            Underrun <= 1'b1;
          end
        end
        S_REQ: begin
          if (cell_load) begin
            // Buffer empty: bypass a same-cycle ack, otherwise blank the cell.
            // The request stays up either way.
            if (ByteAck) begin
              CellByte <= VData;
              SelE     <= InE;
            end else begin
              CellByte <= '0;
              SelE     <= 1'b0;
              Underrun <= 1'b1;
            end
          end else if (ByteAck) begin
            fbuf_byte <= VData;
            fbuf_sel  <= InE;
            state     <= S_FULL;
            ByteReq   <= 1'b0;
          end
        end
        S_FULL: begin
          if (cell_load) begin
            CellByte <= fbuf_byte;
            SelE     <= fbuf_sel;
            state    <= S_REQ;
            ByteReq  <= 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          ByteReq <= 1'b0;
        end
      endcase
    end
  end

  semi_row_tracker #(.CELL_ROWS(CELL_ROWS)) u_row (
    .clk         (Clk),
    .rst_n       (nReset),
    .field_start (FieldStart),
    .line_start  (LineStart),
    .sel         (SelE),
    .row         (RowInCell),
    .seg         (Segment)
  );

endmodule

// File: tb/tb_semi_cell_sequencer.sv
// Bench for semi_cell_sequencer: directed test-plan sequences followed by
// random traffic. A reference model updates on every clock edge and queues
// the expected outputs; a monitor on the falling edge pops and compares.
module tb_semi_cell_sequencer;

  localparam int CELL_PIX  = 8;
  localparam int CELL_ROWS = 12;

  logic       Clk, nReset;
  logic       PixEn, LineStart, FieldStart, InE, ByteAck;
  logic [7:0] VData;
  logic       ByteReq, SelE, Underrun;
  logic [7:0] CellByte;
  logic [2:0] PixCol;
  logic [3:0] RowInCell;
  logic [1:0] Segment;

  semi_cell_sequencer #(.CELL_PIX(CELL_PIX), .CELL_ROWS(CELL_ROWS)) dut (
    .Clk(Clk), .nReset(nReset), .PixEn(PixEn), .LineStart(LineStart),
    .FieldStart(FieldStart), .VData(VData), .InE(InE), .ByteAck(ByteAck),
    .ByteReq(ByteReq), .CellByte(CellByte), .SelE(SelE), .PixCol(PixCol),
    .RowInCell(RowInCell), .Segment(Segment), .Underrun(Underrun)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  function automatic void chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endfunction

  typedef struct packed {
    logic       req;
    logic [7:0] cb;
    logic       se;
    logic [2:0] col;
    logic [3:0] row;
    logic [1:0] seg;
    logic       und;
  } exp_t;

  exp_t sb[$];

  // ---------------- reference model ----------------
  int         m_edges;      // edges since reset release
  logic [8:0] m_buf[$];     // prefetched {sel, byte}, at most one entry
  logic [7:0] m_cb;
  logic       m_se, m_und, m_first;
  int         m_col, m_row;
  bit         m_active, m_load, m_take, m_empty_load;
  logic [8:0] m_ent;
  exp_t       m_exp;

  always @(posedge Clk) begin
    if (!nReset) begin
      m_edges = 0; m_buf.delete();
      m_cb = 8'h00; m_se = 0; m_und = 0; m_first = 1; m_col = 0; m_row = 0;
    end else begin
      m_active     = (m_edges >= 2);
      m_load       = LineStart || (PixEn && m_col == CELL_PIX - 1);
      m_take       = m_active && ByteAck && (m_buf.size() == 0);
      m_empty_load = 0;
      if (m_load) begin
        if (m_buf.size() > 0) begin
          m_ent = m_buf.pop_front();
          m_cb  = m_ent[7:0];
          m_se  = m_ent[8];
        end else if (m_take) begin
          m_cb = VData; m_se = InE;
        end else begin
          m_cb = 8'h00; m_se = 0; m_empty_load = 1;
        end
        m_col = 0;
      end else begin
        if (m_take) m_buf.push_back({InE, VData});
        if (PixEn) m_col = m_col + 1;
      end
      if (FieldStart) m_und = 0;
      if (m_empty_load) m_und = 1;
      if (FieldStart) begin
        m_row = 0; m_first = !LineStart;
      end else if (LineStart) begin
        if (m_first) m_first = 0;
        else m_row = (m_row + 1) % CELL_ROWS;
      end
      if (m_edges < 1000) m_edges++;
    end
    m_exp.req = (m_edges >= 2) && (m_buf.size() == 0);
    m_exp.cb  = m_cb;
    m_exp.se  = m_se;
    m_exp.col = 3'(m_col);
    m_exp.row = 4'(m_row);
    m_exp.seg = m_se ? 2'(m_row / 4) : 2'(m_row / 6);
    m_exp.und = m_und;
    sb.push_back(m_exp);
  end

  // ---------------- monitor ----------------
  exp_t x;
  always @(negedge Clk) begin
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk("byte_req",    {7'd0, ByteReq},   {7'd0, x.req});
      chk("cell_byte",   CellByte,          x.cb);
      chk("sel_e",       {7'd0, SelE},      {7'd0, x.se});
      chk("pix_col",     {5'd0, PixCol},    {5'd0, x.col});
      chk("row_in_cell", {4'd0, RowInCell}, {4'd0, x.row});
      chk("segment",     {6'd0, Segment},   {6'd0, x.seg});
      chk("underrun",    {7'd0, Underrun},  {7'd0, x.und});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic ls, input logic pe, input logic fs,
                      input logic ack, input logic [7:0] vd, input logic ie);
    @(negedge Clk);
    LineStart = ls; PixEn = pe; FieldStart = fs; ByteAck = ack; VData = vd; InE = ie;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 8'h00, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_byte_req"},  {7'd0, ByteReq},   8'h00);
    chk({tag, "_cell_byte"}, CellByte,          8'h00);
    chk({tag, "_sel_e"},     {7'd0, SelE},      8'h00);
    chk({tag, "_pix_col"},   {5'd0, PixCol},    8'h00);
    chk({tag, "_row"},       {4'd0, RowInCell}, 8'h00);
    chk({tag, "_segment"},   {6'd0, Segment},   8'h00);
    chk({tag, "_underrun"},  {7'd0, Underrun},  8'h00);
  endtask

  task automatic release_reset();
    @(negedge Clk); #2 nReset = 1'b1;
  endtask

  initial begin
    nReset = 1'b0;
    PixEn = 0; LineStart = 0; FieldStart = 0; ByteAck = 0; VData = 8'h00; InE = 0;
    #1 check_reset_vals("por");
    repeat (3) @(negedge Clk);
    release_reset();

    // request rises on second edge; ack two cycles later; load via LineStart
    idle(2);
    idle(1);
    step(0, 0, 0, 1, 8'hA5, 1);
    step(1, 0, 0, 0, 8'h00, 0);
    // refill with 0x3C/SG4, then 8 pixels -> wrap and reload
    step(0, 0, 0, 1, 8'h3C, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 8'h00, 0);
    idle(1);

    // row sweep with SG6 cells, then with SG4 cells
    for (int s = 0; s < 2; s++) begin
      step(0, 0, 1, 0, 8'h00, 0);
      for (int i = 0; i < 13; i++) begin
        step(0, 0, 0, 1, 8'($urandom), (s == 0));
        step(1, 0, 0, 0, 8'h00, 0);
      end
      step(0, 0, 0, 1, 8'($urandom), (s == 0));
    end

    // underrun: drain buffer, then load with no ack; it sticks until FieldStart
    step(1, 0, 0, 0, 8'h00, 0);
    step(1, 0, 0, 0, 8'h00, 0);
    step(0, 0, 0, 1, 8'h55, 1);
    step(1, 0, 0, 0, 8'h00, 0);
    idle(2);
    step(0, 0, 1, 0, 8'h00, 0);
    idle(1);

    // bypass: load in REQ with a coincident ack
    step(1, 0, 0, 1, 8'h81, 1);
    idle(2);

    // build PixCol=5, RowInCell=7, FSM FULL, then reset mid-line
    step(0, 0, 1, 0, 8'h00, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 1, 8'($urandom), 1'($urandom));
      step(1, 0, 0, 0, 8'h00, 0);
    end
    step(0, 0, 0, 1, 8'h99, 1);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 8'h00, 0);
    @(negedge Clk); #2 nReset = 1'b0;
    #1 check_reset_vals("mid");
    // stale ack held across reset release must be ignored until REQ
    ByteAck = 1; VData = 8'hEE; InE = 1;
    release_reset();
    idle(3);

    // random traffic
    step(0, 0, 1, 0, 8'h00, 0);
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(15) == 0), 1'($urandom), ($urandom_range(299) == 0),
           ($urandom_range(2) == 0), 8'($urandom), 1'($urandom));
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
